// File: rtl/piso_serializer_pkg.sv
// Shared types and elaboration helpers for the PISO serializer slice.
//   state_e : FSM states (PAR is only reachable when PISO_PARITY_EN is defined)
//   order_e : per-word shift order latched at load
//   beats_f : beats per word (P_WIDTH / LANES)
//   cnt_w_f : beat counter width, max(1, clog2(beats))
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;

  typedef enum logic {
    ORDER_LSB = 1'b0,
    ORDER_MSB = 1'b1
  } order_e;

  function automatic int unsigned beats_f(input int unsigned p_width, input int unsigned lanes);
    return p_width / lanes;
  endfunction

  function automatic int unsigned cnt_w_f(input int unsigned p_width, input int unsigned lanes);
    int unsigned b;
    b = p_width / lanes;
    return (b <= 1) ? 1 : $clog2(b);
  endfunction

endpackage

// File: rtl/piso_serializer_if.sv
// Handshake bundle for the PISO serializer.
//   Parallel side : p_valid, p_ready, p_data, msb_first
//   Serial side   : s_fill, s_valid, s_ready, s_out, s_last
//   slave  modport: the serializer itself
//   master modport: the agent driving words in and consuming beats
interface piso_serializer_if #(
  parameter int unsigned P_WIDTH = 8,
  parameter int unsigned LANES   = 1
);
  logic               p_valid;
  logic               p_ready;
  logic [P_WIDTH-1:0] p_data;
  logic               msb_first;
  logic [LANES-1:0]   s_fill;
  logic               s_valid;
  logic               s_ready;
  logic [LANES-1:0]   s_out;
  logic               s_last;

  modport slave (
    input  p_valid, p_data, msb_first, s_fill, s_ready,
    output p_ready, s_valid, s_out, s_last
  );

  modport master (
    output p_valid, p_data, msb_first, s_fill, s_ready,
    input  p_ready, s_valid, s_out, s_last
  );
endinterface

// File: rtl/piso_serializer_beat_counter.sv
// piso_beat_counter: loadable down-counter with enable and terminal-count flag.
//   clk, rst  : clock, asynchronous active-low reset (count -> 0)
//   load      : load load_val (has priority over en)
//   en        : decrement by one
//   load_val  : value loaded on load
//   tc        : count is zero
module piso_beat_counter #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);
  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      count <= '0;
    else if (load) count <= load_val;
    else if (en)   count <= count - CNT_W'(1);
  end

  assign tc = (count == '0);
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out converter with valid/ready on both sides.
// A P_WIDTH word is emitted as P_WIDTH/LANES beats of LANES bits, LSB- or MSB-first
// (order latched with the word). Supports zero-bubble reload and downstream stall.
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset
//   bus (slave)  : p_valid/p_ready/p_data/msb_first in, s_fill/s_ready in,
//                  s_valid/s_out/s_last out
// Optional feature: define PISO_PARITY_EN to append one even-parity beat per word.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned P_WIDTH = 8,
  parameter int unsigned LANES   = 1
) (
  input  logic               clk,
  input  logic               rst,
  piso_serializer_if.slave   bus
);
  if (LANES == 0 || (P_WIDTH % LANES) != 0) begin : g_width_check
    $error("piso_serializer: P_WIDTH must be a non-zero multiple of LANES");
  end

  localparam int unsigned BEATS = beats_f(P_WIDTH, LANES);
  localparam int unsigned CNT_W = cnt_w_f(P_WIDTH, LANES);

  state_e             state_q, state_d;
  order_e             mode_q;
  logic [P_WIDTH-1:0] sr_q;
  logic [P_WIDTH-1:0] fill_ext;
  logic               tc;
  logic               load;
  logic               shift_en;
  logic               final_beat;
  logic               p_ready_i;
  logic               s_valid_i;
  logic               s_last_i;
  logic [LANES-1:0]   s_out_i;
`ifdef PISO_PARITY_EN
  logic               par_q;
`endif

  // Final beat of the word: the one whose consumption may overlap the next load.
`ifdef PISO_PARITY_EN
  assign final_beat = (state_q == PAR);
`else
  assign final_beat = (state_q == SHIFT) && tc;
`endif

  assign load     = bus.p_valid && p_ready_i;
  assign shift_en = (state_q == SHIFT) && bus.s_ready && !tc;
  assign fill_ext = P_WIDTH'(bus.s_fill);

  piso_beat_counter #(
    .CNT_W (CNT_W)
  ) u_beat_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .en       (shift_en),
    .load_val (CNT_W'(BEATS - 1)),
    .tc       (tc)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Shift datapath; shifts are expressed arithmetically so BEATS=1 needs no special slice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q   <= '0;
      mode_q <= ORDER_LSB;
    end else if (load) begin
      sr_q   <= bus.p_data;
      mode_q <= order_e'(bus.msb_first);
    end else if (shift_en) begin
      if (mode_q == ORDER_MSB) sr_q <= (sr_q << LANES) | fill_ext;
      else                     sr_q <= (sr_q >> LANES) | (fill_ext << (P_WIDTH - LANES));
    end
  end

`ifdef PISO_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      par_q <= 1'b0;
    else if (load) par_q <= ^bus.p_data;
  end
`endif

  // Next-state logic; a load in SHIFT/PAR can only happen on the final beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load) state_d = SHIFT;
      end
      SHIFT: begin
        if (bus.s_ready && tc) begin
`ifdef PISO_PARITY_EN
          state_d = PAR;
`else
          state_d = load ? SHIFT : IDLE;
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        if (bus.s_ready) state_d = load ? SHIFT : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Output logic; p_ready is gated by rst so it stays low throughout reset.
  always_comb begin
    p_ready_i = rst && ((state_q == IDLE) || (final_beat && bus.s_ready));
    s_valid_i = 1'b0;
    s_out_i   = '0;
    s_last_i  = final_beat;
    case (state_q)
      SHIFT: begin
        s_valid_i = 1'b1;
        s_out_i   = (mode_q == ORDER_MSB) ? sr_q[P_WIDTH-1 -: LANES] : sr_q[LANES-1:0];
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        s_valid_i = 1'b1;
        s_out_i   = LANES'(par_q);
      end
`endif
      default: begin
        s_valid_i = 1'b0;
        s_out_i   = '0;
      end
    endcase
  end

  assign bus.p_ready = p_ready_i;
  assign bus.s_valid = s_valid_i;
  assign bus.s_out   = s_out_i;
  assign bus.s_last  = s_last_i;
endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one 8x1-lane and one 8x2-lane instance.
// Expected beats come from a word-level model (bit slices of the word, plus the
// parity beat when PISO_PARITY_EN is defined).
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam int PAR_BEATS = 1;
`else
  localparam int PAR_BEATS = 0;
`endif
  localparam int N1 = 8 + PAR_BEATS;
  localparam int N2 = 4 + PAR_BEATS;

  typedef struct {
    logic [7:0] beat;
    bit         last;
  } beat_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  piso_serializer_if #(.P_WIDTH(8), .LANES(1)) if1 ();
  piso_serializer_if #(.P_WIDTH(8), .LANES(2)) if2 ();

  piso_serializer #(.P_WIDTH(8), .LANES(1)) u1 (.clk(clk), .rst(rst), .bus(if1));
  piso_serializer #(.P_WIDTH(8), .LANES(2)) u2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat k of word w for the given lane count; index past the data beats is parity.
  function automatic logic [7:0] exp_beat(input logic [7:0] w, input bit msb,
                                          input int lanes, input int k);
    logic [7:0] mask;
    mask = 8'((1 << lanes) - 1);
    if (k >= 8 / lanes) return {7'b0, ^w};
    if (!msb) return (w >> (k * lanes)) & mask;
    return (w >> (8 - (k + 1) * lanes)) & mask;
  endfunction

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (if1.p_ready !== 1'b0) begin bad++; $display("FAIL rst_p_ready1: got %b want 0", if1.p_ready); end
    total++; if (if1.s_valid !== 1'b0) begin bad++; $display("FAIL rst_s_valid1: got %b want 0", if1.s_valid); end
    total++; if (if1.s_last !== 1'b0) begin bad++; $display("FAIL rst_s_last1: got %b want 0", if1.s_last); end
    total++; if (if1.s_out !== 1'b0) begin bad++; $display("FAIL rst_s_out1: got %h want 0", if1.s_out); end
    total++; if (if2.p_ready !== 1'b0) begin bad++; $display("FAIL rst_p_ready2: got %b want 0", if2.p_ready); end
    total++; if (if2.s_out !== 2'b00) begin bad++; $display("FAIL rst_s_out2: got %h want 0", if2.s_out); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (if1.p_ready !== 1'b1) begin bad++; $display("FAIL rel_p_ready1: got %b want 1", if1.p_ready); end
    total++; if (if2.p_ready !== 1'b1) begin bad++; $display("FAIL rel_p_ready2: got %b want 1", if2.p_ready); end
    total++; if (if1.s_valid !== 1'b0) begin bad++; $display("FAIL rel_s_valid1: got %b want 0", if1.s_valid); end
  endtask

  // 8'h1E on the 1-lane instance; msb_first is toggled mid-word and must be ignored.
  task automatic test_order(input bit msb);
    logic [7:0] e;
    @(negedge clk);
    if1.p_valid = 1'b1; if1.p_data = 8'h1E; if1.msb_first = msb; if1.s_ready = 1'b1;
    #1;
    total++; if (if1.p_ready !== 1'b1) begin bad++; $display("FAIL ord_accept: got %b want 1", if1.p_ready); end
    for (int k = 0; k < N1; k++) begin
      @(negedge clk);
      if1.p_valid = 1'b0; if1.msb_first = ~msb; if1.s_fill = 1'($urandom);
      #1;
      e = exp_beat(8'h1E, msb, 1, k);
      total++; if (if1.s_valid !== 1'b1) begin bad++; $display("FAIL ord_valid[%0d]: got %b want 1", k, if1.s_valid); end
      total++; if ({7'b0, if1.s_out} !== e) begin bad++; $display("FAIL ord_out[%0d] msb=%0d: got %h want %h", k, msb, if1.s_out, e); end
      total++; if (if1.s_last !== (k == N1 - 1)) begin bad++; $display("FAIL ord_last[%0d]: got %b want %b", k, if1.s_last, k == N1 - 1); end
      total++; if (if1.p_ready !== (k == N1 - 1)) begin bad++; $display("FAIL ord_p_ready[%0d]: got %b want %b", k, if1.p_ready, k == N1 - 1); end
    end
    @(negedge clk);
    #1;
    total++; if (if1.s_valid !== 1'b0) begin bad++; $display("FAIL ord_idle: got %b want 0", if1.s_valid); end
  endtask

  task automatic test_lanes2;
    logic [7:0] words [2];
    bit         msbs  [2];
    logic [7:0] e;
    words[0] = 8'hB4;          msbs[0] = 1'b0;
    words[1] = 8'($urandom);   msbs[1] = 1'b1;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      if2.p_valid = 1'b1; if2.p_data = words[w]; if2.msb_first = msbs[w]; if2.s_ready = 1'b1;
      for (int k = 0; k < N2; k++) begin
        @(negedge clk);
        if2.p_valid = 1'b0; if2.s_fill = 2'($urandom);
        #1;
        e = exp_beat(words[w], msbs[w], 2, k);
        total++; if (if2.s_valid !== 1'b1) begin bad++; $display("FAIL l2_valid[%0d]: got %b want 1", k, if2.s_valid); end
        total++; if ({6'b0, if2.s_out} !== e) begin bad++; $display("FAIL l2_out w=%h [%0d]: got %h want %h", words[w], k, if2.s_out, e); end
        total++; if (if2.s_last !== (k == N2 - 1)) begin bad++; $display("FAIL l2_last[%0d]: got %b want %b", k, if2.s_last, k == N2 - 1); end
      end
      @(negedge clk);
      #1;
      total++; if (if2.s_valid !== 1'b0) begin bad++; $display("FAIL l2_idle: got %b want 0", if2.s_valid); end
    end
  endtask

  // Downstream stalls for 3 cycles while beat 3 is shown.
  task automatic test_stall;
    logic [7:0] w, e;
    bit         msb;
    w = 8'($urandom); msb = 1'($urandom);
    @(negedge clk);
    if1.p_valid = 1'b1; if1.p_data = w; if1.msb_first = msb; if1.s_ready = 1'b1;
    for (int k = 0; k < N1; k++) begin
      e = exp_beat(w, msb, 1, k);
      if (k == 2) begin
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          if1.p_valid = 1'b0; if1.s_ready = 1'b0; if1.s_fill = 1'($urandom);
          #1;
          total++; if (if1.s_valid !== 1'b1) begin bad++; $display("FAIL st_hold_valid[%0d]: got %b want 1", s, if1.s_valid); end
          total++; if ({7'b0, if1.s_out} !== e) begin bad++; $display("FAIL st_hold_out[%0d]: got %h want %h", s, if1.s_out, e); end
          total++; if (if1.p_ready !== 1'b0) begin bad++; $display("FAIL st_hold_p_ready[%0d]: got %b want 0", s, if1.p_ready); end
        end
      end
      @(negedge clk);
      if1.p_valid = 1'b0; if1.s_ready = 1'b1;
      #1;
      total++; if ({7'b0, if1.s_out} !== e) begin bad++; $display("FAIL st_out[%0d]: got %h want %h", k, if1.s_out, e); end
      total++; if (if1.s_last !== (k == N1 - 1)) begin bad++; $display("FAIL st_last[%0d]: got %b want %b", k, if1.s_last, k == N1 - 1); end
    end
    @(negedge clk);
    #1;
    total++; if (if1.s_valid !== 1'b0) begin bad++; $display("FAIL st_idle: got %b want 0", if1.s_valid); end
  endtask

  // 8'h1E then 8'hA5 (MSB-first) with p_valid held: no idle cycle between words.
  task automatic test_back_to_back;
    logic [7:0] e;
    bit         fin;
    @(negedge clk);
    if1.p_valid = 1'b1; if1.p_data = 8'h1E; if1.msb_first = 1'b0; if1.s_ready = 1'b1;
    for (int k = 0; k < N1; k++) begin
      @(negedge clk);
      if1.p_data = 8'hA5; if1.msb_first = 1'b1;
      #1;
      e = exp_beat(8'h1E, 1'b0, 1, k);
      fin = (k == N1 - 1);
      total++; if ({7'b0, if1.s_out} !== e) begin bad++; $display("FAIL b2b_w1[%0d]: got %h want %h", k, if1.s_out, e); end
      total++; if (if1.p_ready !== fin) begin bad++; $display("FAIL b2b_p_ready[%0d]: got %b want %b", k, if1.p_ready, fin); end
    end
    for (int k = 0; k < N1; k++) begin
      @(negedge clk);
      if1.p_valid = 1'b0;
      #1;
      e = exp_beat(8'hA5, 1'b1, 1, k);
      total++; if (if1.s_valid !== 1'b1) begin bad++; $display("FAIL b2b_w2_valid[%0d]: got %b want 1", k, if1.s_valid); end
      total++; if ({7'b0, if1.s_out} !== e) begin bad++; $display("FAIL b2b_w2[%0d]: got %h want %h", k, if1.s_out, e); end
      total++; if (if1.s_last !== (k == N1 - 1)) begin bad++; $display("FAIL b2b_w2_last[%0d]: got %b want %b", k, if1.s_last, k == N1 - 1); end
    end
    @(negedge clk);
    #1;
    total++; if (if1.s_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", if1.s_valid); end
  endtask

  task automatic test_reset_mid_word;
    logic [7:0] w;
    w = 8'($urandom) | 8'h01;
    @(negedge clk);
    if1.p_valid = 1'b1; if1.p_data = w; if1.msb_first = 1'b0; if1.s_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if1.p_valid = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (if1.s_valid !== 1'b0) begin bad++; $display("FAIL rmw_s_valid: got %b want 0", if1.s_valid); end
    total++; if (if1.p_ready !== 1'b0) begin bad++; $display("FAIL rmw_p_ready: got %b want 0", if1.p_ready); end
    total++; if (if1.s_out !== 1'b0) begin bad++; $display("FAIL rmw_s_out: got %h want 0", if1.s_out); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (if1.p_ready !== 1'b1) begin bad++; $display("FAIL rmw_rel_p_ready: got %b want 1", if1.p_ready); end
    total++; if (if1.s_valid !== 1'b0) begin bad++; $display("FAIL rmw_rel_s_valid: got %b want 0", if1.s_valid); end
    @(negedge clk);
    #1;
    total++; if (if1.s_valid !== 1'b0) begin bad++; $display("FAIL rmw_no_partial: got %b want 0", if1.s_valid); end
    total++; if (if1.s_out !== 1'b0) begin bad++; $display("FAIL rmw_rel_s_out: got %h want 0", if1.s_out); end
  endtask

  // Random words, order, fill and stalls on the 2-lane instance; the model is a
  // queue of pending beats for the word currently being emitted.
  task automatic test_random;
    beat_t      q[$];
    beat_t      b;
    bit         pend;
    bit         msb;
    bit         exp_ready;
    logic [7:0] w;
    pend = 1'b0; w = '0; msb = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!pend && ($urandom_range(0, 2) != 0)) begin
        pend = 1'b1; w = 8'($urandom); msb = 1'($urandom);
      end
      if2.p_valid   = pend;
      if2.p_data    = pend ? w : 8'($urandom);
      if2.msb_first = pend ? msb : 1'($urandom);
      if2.s_ready   = ($urandom_range(0, 3) != 0);
      if2.s_fill    = 2'($urandom);
      #1;
      exp_ready = (q.size() == 0) || (q.size() == 1 && if2.s_ready);
      total++; if (if2.p_ready !== exp_ready) begin bad++; $display("FAIL rnd_p_ready c=%0d: got %b want %b", c, if2.p_ready, exp_ready); end
      total++; if (if2.s_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_s_valid c=%0d: got %b want %b", c, if2.s_valid, q.size() != 0); end
      if (q.size() != 0) begin
        total++; if ({6'b0, if2.s_out} !== q[0].beat) begin bad++; $display("FAIL rnd_s_out c=%0d: got %h want %h", c, if2.s_out, q[0].beat); end
        total++; if (if2.s_last !== q[0].last) begin bad++; $display("FAIL rnd_s_last c=%0d: got %b want %b", c, if2.s_last, q[0].last); end
      end
      if (q.size() != 0 && if2.s_ready) void'(q.pop_front());
      if (pend && exp_ready) begin
        for (int k = 0; k < N2; k++) begin
          b.beat = exp_beat(w, msb, 2, k);
          b.last = (k == N2 - 1);
          q.push_back(b);
        end
        pend = 1'b0;
      end
    end
    // Drain whatever is left.
    @(negedge clk);
    if2.p_valid = 1'b0; if2.s_ready = 1'b1;
    repeat (N2 + 1) @(negedge clk);
    #1;
    total++; if (if2.s_valid !== 1'b0) begin bad++; $display("FAIL rnd_drain: got %b want 0", if2.s_valid); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0;
    if1.p_valid = 1'b0; if1.p_data = '0; if1.msb_first = 1'b0; if1.s_fill = '0; if1.s_ready = 1'b1;
    if2.p_valid = 1'b0; if2.p_data = '0; if2.msb_first = 1'b0; if2.s_fill = '0; if2.s_ready = 1'b1;
    test_reset();
    test_order(1'b0);
    test_order(1'b1);
    test_lanes2();
    test_stall();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule
